// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage. Owns the program counter, drives a
// combinational-read instruction memory and buffers fetched words with their
// PCs in a 2-entry circular queue that feeds decode over valid/ready.
// A redirect from execute flushes the queue and restarts fetch at the target.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 13,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_inst,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_pc_plus4,
  output logic               misalign_err
);

  localparam int DEPTH = 2;

  // Architectural state
  logic [31:0] pc_q, pc_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        misalign_q, misalign_d;

  // Queue storage: data only, validity is tracked by count_q
  logic [31:0] entry_pc_q   [DEPTH];
  logic [31:0] entry_inst_q [DEPTH];
  logic [DEPTH-1:0] entry_we;

  logic pop;
  logic push;
  logic full;
  logic empty;

  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);

  // Handshake: an empty queue ignores out_ready; a full queue can still take
  // a new word in the same cycle the head leaves.
  assign pop  = ~empty & out_ready;
  assign push = ~redirect_valid & (~full | pop);

  // Per-entry write enables: only the slot under the write pointer is loaded
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign entry_we[gi] = push & (wr_ptr_q == 1'(gi));
    end
  endgenerate

  // Next-state logic for pc, pointers, occupancy and the sticky error flag
  always_comb begin
    pc_d       = pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    if (redirect_valid) begin
      // Flush wins over a simultaneous pop; the target is fetched next cycle.
      pc_d       = {redirect_pc[31:2], 2'b00};
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      count_d    = 2'd0;
      misalign_d = misalign_q | (redirect_pc[1:0] != 2'b00);
    end else begin
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
        pc_d     = pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Control registers with synchronous reset; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Queue payload capture; a reset-cycle push is harmless since count stays 0
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_we[i]) begin
        entry_pc_q[i]   <= pc_q;
        entry_inst_q[i] <= imem_data;
      end
    end
  end

  // Memory address comes straight from the pc register; high bits alias
  assign imem_addr = pc_q[IMEM_AW+1:2];

  // Decode-side outputs are decoded from registers only
  always_comb begin
    out_valid = ~empty;
    out_pc    = 32'd0;
    out_inst  = NOP_INST;
    if (~empty) begin
      out_pc   = entry_pc_q[rd_ptr_q];
      out_inst = entry_inst_q[rd_ptr_q];
    end
  end

  assign out_pc_plus4 = out_pc + 32'd4;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table for the documented scenarios, a short
// back-to-back redirect sequence, then randomized traffic checked against a
// queue-based reference model.
module tb_fetch_queue;

  localparam int          IMEM_AW  = 13;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic                clk = 1'b0;
  logic                rst;
  logic [IMEM_AW-1:0]  imem_addr;
  logic [31:0]         imem_data;
  logic                redirect_valid;
  logic [31:0]         redirect_pc;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_inst;
  logic [31:0]         out_pc;
  logic [31:0]         out_pc_plus4;
  logic                misalign_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:(1<<IMEM_AW)-1];
  assign imem_data = mem[imem_addr];

  fetch_queue #(.RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of {pc, inst} plus fetch pc and error flag
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc;
  logic        merr;

  function automatic logic [31:0] word_at(logic [31:0] byte_pc);
    return mem[byte_pc[IMEM_AW+1:2]];
  endfunction

  task automatic model_update();
    int  n;
    bit  mpop;
    n    = mq.size();
    mpop = (n != 0) && out_ready;
    if (rst) begin
      mpc = RESET_PC;
      mq.delete();
      merr = 1'b0;
    end else if (redirect_valid) begin
      mq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) merr = 1'b1;
    end else begin
      if (mpop) void'(mq.pop_front());
      if (n < 2 || mpop) begin
        mq.push_back('{mpc, word_at(mpc)});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: inputs already driven; advance model with DUT, sample at +1
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_model(string tag);
    logic        v;
    logic [31:0] p, ins;
    v   = (mq.size() != 0);
    p   = v ? mq[0].pc : 32'd0;
    ins = v ? mq[0].inst : NOP;
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".pc"}, out_pc, p);
    chk({tag, ".inst"}, out_inst, ins);
    chk({tag, ".pc4"}, out_pc_plus4, p + 32'd4);
    chk({tag, ".addr"}, {19'd0, imem_addr}, {19'd0, mpc[IMEM_AW+1:2]});
    chk({tag, ".err"}, {31'd0, misalign_err}, {31'd0, merr});
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
    logic [12:0] e_addr;
    logic        e_err;
  } row_t;

  function automatic row_t mk(logic r, logic rv, logic [31:0] rpc, logic rdy,
                              logic v, logic [31:0] p, logic [31:0] ins,
                              logic [31:0] p4, logic [12:0] a, logic e);
    row_t t;
    t.rst = r; t.rv = rv; t.rpc = rpc; t.rdy = rdy;
    t.e_valid = v; t.e_pc = p; t.e_inst = ins; t.e_pc4 = p4;
    t.e_addr = a; t.e_err = e;
    return t;
  endfunction

  row_t tbl[21];

  initial begin
    for (int i = 0; i < (1 << IMEM_AW); i++) mem[i] = 32'h5A00_0000 | i;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h00ff_f0b7;
    mem[2] = 32'heff0_8093;

    // Free-run after reset
    tbl[0]  = mk(1, 0, 0, 1, 0, 32'h0, NOP,          32'h4, 13'd0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 1, 32'h0, 32'h00000013, 32'h4, 13'd1, 0);
    tbl[2]  = mk(0, 0, 0, 1, 1, 32'h4, 32'h00fff0b7, 32'h8, 13'd2, 0);
    tbl[3]  = mk(0, 0, 0, 1, 1, 32'h8, 32'heff08093, 32'hC, 13'd3, 0);
    // Backpressure from pc=0, then release
    tbl[4]  = mk(1, 0, 0, 0, 0, 32'h0, NOP,          32'h4, 13'd0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 1, 32'h0, 32'h00000013, 32'h4, 13'd1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 1, 32'h0, 32'h00000013, 32'h4, 13'd2, 0);
    tbl[7]  = mk(0, 0, 0, 0, 1, 32'h0, 32'h00000013, 32'h4, 13'd2, 0);
    tbl[8]  = mk(0, 0, 0, 0, 1, 32'h0, 32'h00000013, 32'h4, 13'd2, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 32'h0, 32'h00000013, 32'h4, 13'd2, 0);
    tbl[10] = mk(0, 0, 0, 1, 1, 32'h4, 32'h00fff0b7, 32'h8, 13'd3, 0);
    tbl[11] = mk(0, 0, 0, 1, 1, 32'h8, 32'heff08093, 32'hC, 13'd4, 0);
    tbl[12] = mk(0, 0, 0, 1, 1, 32'hC, 32'h5A000003, 32'h10, 13'd5, 0);
    // Redirect to 0x28 with a full queue and a pop in the same cycle
    tbl[13] = mk(0, 1, 32'h28, 1, 0, 32'h0, NOP,     32'h4, 13'd10, 0);
    tbl[14] = mk(0, 0, 0, 1, 1, 32'h28, 32'h5A00000A, 32'h2C, 13'd11, 0);
    // Misaligned redirect, then wrap target
    tbl[15] = mk(0, 1, 32'h31, 1, 0, 32'h0, NOP,     32'h4, 13'd12, 1);
    tbl[16] = mk(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0, NOP, 32'h4, 13'h1FFF, 1);
    tbl[17] = mk(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h5A001FFF, 32'h0, 13'd0, 1);
    tbl[18] = mk(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h5A001FFF, 32'h0, 13'd1, 1);
    // Reset mid-stream with a full queue and a redirect asserted
    tbl[19] = mk(1, 1, 32'h40, 1, 0, 32'h0, NOP,     32'h4, 13'd0, 0);
    tbl[20] = mk(0, 0, 0, 1, 1, 32'h0, 32'h00000013, 32'h4, 13'd1, 0);

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
    mpc = RESET_PC; merr = 1'b0;
    cycle();

    for (int i = 0; i < 21; i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      rst = tbl[i].rst; redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc; out_ready = tbl[i].rdy;
      cycle();
      $display("vec %0d rst=%0d rv=%0d rpc=%h rdy=%0d -> v=%0d pc=%h inst=%h addr=%h err=%0d",
               i, rst, redirect_valid, redirect_pc, out_ready,
               out_valid, out_pc, out_inst, imem_addr, misalign_err);
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, tbl[i].e_valid});
      chk({tag, ".pc"}, out_pc, tbl[i].e_pc);
      chk({tag, ".inst"}, out_inst, tbl[i].e_inst);
      chk({tag, ".pc4"}, out_pc_plus4, tbl[i].e_pc4);
      chk({tag, ".addr"}, {19'd0, imem_addr}, {19'd0, tbl[i].e_addr});
      chk({tag, ".err"}, {31'd0, misalign_err}, {31'd0, tbl[i].e_err});
    end

    // Back-to-back redirects: the last target wins
    rst = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100; cycle();
    redirect_pc = 32'h200; cycle();
    chk("b2b.addr", {19'd0, imem_addr}, 32'h80);
    chk("b2b.valid0", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b0; cycle();
    $display("b2b: v=%0d pc=%h inst=%h addr=%h", out_valid, out_pc, out_inst, imem_addr);
    chk("b2b.valid1", {31'd0, out_valid}, 32'd1);
    chk("b2b.pc", out_pc, 32'h200);
    chk("b2b.inst", out_inst, 32'h5A000080);

    // Randomized traffic against the model
    rst = 1'b1; redirect_valid = 1'b0; cycle();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      rst            = ($urandom_range(0, 199) == 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 4095);
      if ($urandom_range(0, 7) != 0) r[1:0] = 2'b00;
      redirect_pc = r;
      check_model($sformatf("rnd%0d", c));
      if (c % 250 == 0)
        $display("rnd %0d rst=%0d rv=%0d rpc=%h rdy=%0d v=%0d pc=%h",
                 c, rst, redirect_valid, redirect_pc, out_ready, out_valid, out_pc);
      cycle();
    end
    check_model("rnd_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory and feeds the decode stage.
- Owns the program counter and drives the word address into the combinational-read instruction memory (13-bit word address, 32-bit data).
- Captures each fetched word together with its PC into a 2-entry queue.
- Presents the queue head to decode over a valid/ready handshake; supports a branch/jump redirect that flushes the queue.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- IMEM_AW, 13, instruction memory word-address width.
- NOP_INST, 32'h0000_0013, value driven on out_inst while out_valid is low.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  IMEM_AW  word address to instruction memory; always equals pc[IMEM_AW+1:2].
- imem_data  input  32  instruction word, valid in the same cycle as imem_addr (combinational memory).
- redirect_valid  input  1  taken branch/jump from execute; flush and restart.
- redirect_pc  input  32  byte target of the redirect.
- out_valid  output  1  queue head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_inst  output  32  head instruction word.
- out_pc  output  32  head byte PC.
- out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
- misalign_err  output  1  sticky flag: a redirect target had pc[1:0] != 0.

Behaviour:
- State:
  - pc register (32 b).
  - 2-entry circular queue of {pc, inst}, with rd_ptr, wr_ptr (1 b each) and count (0..2).
  - misalign_err flop.
- Definitions:
  - pop = out_valid & out_ready.
  - push = ~redirect_valid & (count < 2 | pop).
- Reset (rst=1 at a rising edge):
  - pc=RESET_PC, count=0, pointers=0, misalign_err=0.
  - Outputs during and after reset until the first push: out_valid=0, out_inst=NOP_INST, out_pc=0, out_pc_plus4=4.
  - Reset overrides redirect and the handshake in the same cycle.
- Normal cycle (no redirect):
  - If push: write {pc, imem_data} at wr_ptr, advance wr_ptr, pc <= pc+4.
  - If pop: advance rd_ptr.
  - count <= count + push - pop.
- Full queue (count=2):
  - With out_ready=0: push=0, pc holds, imem_addr holds.
  - With out_ready=1: push and pop occur in the same cycle, count stays 2, throughput is 1 instruction/cycle.
- Empty queue (count=0): out_valid=0, and out_ready is ignored.
- Redirect (redirect_valid=1, rst=0):
  - Queue cleared: count=0, rd_ptr=wr_ptr=0. This applies even if pop=1 in the same cycle; decode treats the head as consumed, and the flush still wins.
  - No push that cycle.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - If redirect_pc[1:0] != 0, misalign_err <= 1 (sticky until rst).
- Latency:
  - The redirect target is fetched in the cycle after the redirect edge.
  - The target appears at out_valid/out_pc one cycle later (2 edges after redirect is sampled).
  - After reset deasserts, the first edge pushes RESET_PC, so out_valid=1 from the second cycle.
- Back-to-back redirects: the last one wins; each flushes the queue.
- PC arithmetic:
  - pc+4 wraps modulo 2^32.
  - imem_addr truncates pc to bits [IMEM_AW+1:2], so fetches alias every 2^(IMEM_AW+2) bytes; no range check is made.
  - Memory words beyond the implemented depth return unspecified data, which is forwarded unchanged.
- Outputs are driven from queue registers only; there is no combinational path from imem_data or redirect_* to out_*.
- imem_addr depends only on the pc register.

Test Plan:
- Reset then free-run (out_ready=1), IMEM[0..2]=00000013, 00fff0b7, eff08093:
  - Cycle after reset: out_valid=0, out_inst=00000013.
  - Then out_pc=0,4,8 with out_inst=00000013, 00fff0b7, eff08093 on consecutive cycles.
  - out_pc_plus4=4,8,C.
- Backpressure (out_ready=0 for 5 cycles from pc=0):
  - count saturates at 2, imem_addr holds at 2, out_pc stays 0.
  - On release of out_ready: out_pc sequence 0,4,8,C with no gaps or duplicates.
- Redirect to 0x28 while count=2 and out_ready=1:
  - Next cycle out_valid=0, imem_addr=10.
  - Following cycle out_pc=0x28, out_inst=IMEM[10].
  - misalign_err stays 0.
- Redirect to 0x31:
  - pc becomes 0x30 and misalign_err=1.
  - misalign_err remains 1 across later redirects until rst.
- Wrap: redirect to 0xFFFF_FFFC:
  - imem_addr=0x1FFF.
  - Next fetch pc=0x0000_0000, out_pc_plus4 of the first entry = 0.
- Reset asserted mid-stream with count=2 and redirect_valid=1:
  - Next cycle out_valid=0, pc=RESET_PC.
  - First post-reset instruction has out_pc=0.
